// File: rtl/dma_engine_pkg.sv
// -----------------------------------------------------------------------------
// dma_engine_pkg
// Shared definitions for the DMA engine and the memory controller that hosts
// its register window: datapath widths, register-select encodings and the
// transfer FSM state encoding.
// -----------------------------------------------------------------------------
package dma_engine_pkg;

  localparam int DMA_SRC_W  = 32;
  localparam int DMA_DST_W  = 16;
  localparam int DMA_DATA_W = 16;

  // Register select values carried on dma_mode
  localparam logic [1:0] DMA_MODE_SRC_L = 2'd0;
  localparam logic [1:0] DMA_MODE_SRC_U = 2'd1;
  localparam logic [1:0] DMA_MODE_DST   = 2'd2;
  localparam logic [1:0] DMA_MODE_AMT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_engine.sv
// -----------------------------------------------------------------------------
// dma_engine
// Bus-initiator DMA. The CPU programs source (SRC_L/SRC_U), destination (DST)
// and word count (AMT); the AMT write starts the copy. Each word is fetched
// from the 32-bit-addressed source port and written into the 16-bit memory
// map. While a transfer runs the engine owns the data bus (bus_req).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   dma_en, dma_mode    CPU hits the register window / register select
//   memwrite, writedata CPU write strobe and data
//   reg_rdata           register readback (combinational on dma_mode)
//   src_req, src_addr   source read request and word address
//   src_data, src_valid source read data and its qualifier
//   bus_req             DMA owns the bus (CPU stall)
//   bus_addr, bus_write, bus_wdata  destination write port
//   busy                transfer in progress
//   done                one-cycle pulse at the end of a transfer
// -----------------------------------------------------------------------------
module dma_engine
  import dma_engine_pkg::*;
#(
  parameter int SRC_W  = DMA_SRC_W,
  parameter int DST_W  = DMA_DST_W,
  parameter int DATA_W = DMA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_en,
  input  logic [1:0]        dma_mode,
  input  logic              memwrite,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              src_req,
  output logic [SRC_W-1:0]  src_addr,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              bus_req,
  output logic [DST_W-1:0]  bus_addr,
  output logic              bus_write,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              busy,
  output logic              done
);

  dma_state_t          state_r;
  logic [SRC_W-1:0]    src_r;
  logic [DST_W-1:0]    dst_r;
  logic [DATA_W-1:0]   cnt_r;
  logic                reg_wr_s;

  // CPU register writes are accepted only while the engine is idle
  always_comb begin
    reg_wr_s = 1'b0;
    if (dma_en && memwrite && (state_r == ST_IDLE)) begin
      reg_wr_s = 1'b1;
    end else begin
      reg_wr_s = 1'b0;
    end
  end

  // Register readback mux; shows the live counters while a transfer runs
  always_comb begin
    reg_rdata = '0;
    case (dma_mode)
      DMA_MODE_SRC_L: reg_rdata = src_r[DATA_W-1:0];
      DMA_MODE_SRC_U: reg_rdata = src_r[SRC_W-1:DATA_W];
      DMA_MODE_DST:   reg_rdata = DATA_W'(dst_r);
      DMA_MODE_AMT:   reg_rdata = cnt_r;
      default:        reg_rdata = '0;
    endcase
  end

  // Transfer FSM. Outputs are registered and set for the state being entered,
  // so they always line up with state_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      src_r     <= '0;
      dst_r     <= '0;
      cnt_r     <= '0;
      src_req   <= 1'b0;
      src_addr  <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_write <= 1'b0;
      bus_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (reg_wr_s) begin
            case (dma_mode)
              DMA_MODE_SRC_L: src_r[DATA_W-1:0]     <= writedata;
              DMA_MODE_SRC_U: src_r[SRC_W-1:DATA_W] <= writedata;
              DMA_MODE_DST:   dst_r                 <= DST_W'(writedata);
              DMA_MODE_AMT: begin
                cnt_r <= writedata;
                // A zero count skips straight to DONE: no bus activity
                if (writedata != '0) begin
                  state_r  <= ST_FETCH;
                  src_req  <= 1'b1;
                  src_addr <= src_r;
                  bus_req  <= 1'b1;
                  busy     <= 1'b1;
                end else begin
                  state_r <= ST_DONE;
                  done    <= 1'b1;
                end
              end
              default: state_r <= ST_IDLE;
            endcase
          end
        end

        ST_FETCH: begin
          // Hold src_addr steady until the source answers
          if (src_valid) begin
            state_r   <= ST_WRITE;
            src_req   <= 1'b0;
            bus_write <= 1'b1;
            bus_addr  <= dst_r;
            bus_wdata <= src_data;
          end
        end

        ST_WRITE: begin
          bus_write <= 1'b0;
          src_r     <= src_r + SRC_W'(1);
          dst_r     <= dst_r + DST_W'(1);
          cnt_r     <= cnt_r - DATA_W'(1);
          if (cnt_r == DATA_W'(1)) begin
            state_r <= ST_DONE;
            bus_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state_r  <= ST_FETCH;
            src_req  <= 1'b1;
            src_addr <= src_r + SRC_W'(1);
          end
        end

        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r   <= ST_IDLE;
          src_req   <= 1'b0;
          bus_req   <= 1'b0;
          bus_write <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
